ula_multiciclo: RTL and testbench
=================================

# ula_multiciclo

Multi-cycle ALU executing the 4-bit `controle` code produced by the ALU-control decoder of the MIPS-32 datapath. It is the consumer end of that interface. Single-cycle operations (add, sub, logic, shifts, compares, branch tests) complete one clock after issue. Signed multiply and divide run as iterative 32-step shift-add and restoring-division engines. A start/ready handshake stalls the datapath during multi-cycle work.

## Interface
- No parameters; data width fixed at 32.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start pulse; samples `controle`, `a`, `b`.
- `controle`  in  4  operation code: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 sll, 6 srl, 7 beq, 8 bneq, 9 blz, 10 slt, 11 sgt, 12 mult, 13 div; 14/15 invalid.
- `a`, `b`  in  32 each  operands; two's complement where signed.
- `resultado`  out  32  main result (low product / quotient).
- `hi`  out  32  high product / remainder; 0 for all other ops.
- `zero`  out  1  `resultado == 0`.
- `desvio`  out  1  branch-taken flag (codes 7–9 only).
- `overflow`  out  1  signed overflow (codes 0, 1 only).
- `erro`  out  1  invalid code or divide by zero.
- `ocupado`  out  1  multi-cycle op in progress.
- `pronto`  out  1  one-cycle pulse; outputs valid.

## Operation
- FSM states: OCIOSO, CALC, FIM.
- Reset (asynchronous, `reset`=0): state OCIOSO, all outputs 0, iteration counter 0, internal registers 0. A reset asserted mid-operation aborts the operation; no `pronto` is issued.
- OCIOSO + `iniciar`=1 with codes 0–11, 14, 15:
  - Compute and register the result, set `pronto`=1, remain in OCIOSO.
  - 0/1: `a±b` mod 2^32. `overflow` = operand signs as seen by the op agree and the result sign differs.
  - 2/3: bitwise and / or. 4: `~a`.
  - 5/6: `a` shifted left / right logically by `b[4:0]`.
  - 7: `resultado=a-b`, `desvio=(a==b)`. 8: `resultado=a-b`, `desvio=(a!=b)`. 9: `resultado=a`, `desvio=a[31]`.
  - 10: `resultado = (a<b signed) ? 1 : 0`. 11: `resultado = (a>b signed) ? 1 : 0`.
  - 14/15: `resultado=0`, `hi=0`, `erro=1`.
- OCIOSO + `iniciar` + code 12 (mult): latch `|a|`, `|b|` and result sign; go to CALC.
  - Each CALC cycle performs one shift-add step over a 64-bit accumulator.
- OCIOSO + `iniciar` + code 13 (div):
  - If `b==0`: finish immediately as single-cycle with `resultado=32'hFFFFFFFF`, `hi=a`, `erro=1`.
  - Otherwise latch magnitudes and go to CALC; each CALC cycle performs one restoring subtract-shift step.
- CALC: counter 0→31, one step per cycle; after step 31 go to FIM.
- FIM: apply sign correction, register `{hi,resultado}`, pulse `pronto`, return to OCIOSO.
  - mult: 64-bit signed product.
  - div: truncation toward zero; remainder takes the sign of `a`.
  - Special case: `32'h80000000 / -1` gives quotient `32'h80000000`, remainder 0, `erro=0`.
- Flags not relevant to the executed op are driven 0. `zero` is always computed from the final `resultado`.
- `iniciar` while `ocupado`=1 is ignored; operands are not re-sampled.
- Outputs hold their last values until the next `pronto`.

## Timing
- `iniciar` sampled at edge k.
- Single-cycle ops (including div-by-0 and invalid codes): outputs valid and `pronto`=1 during the cycle after edge k; `ocupado` stays 0.
- mult/div: `ocupado`=1 after edges k through k+32; FIM at edge k+33. `pronto`=1 and `ocupado`=0 after edge k+33. Total latency 33 cycles.
- `pronto` is high for exactly one cycle. A new `iniciar` is accepted in that same cycle, so back-to-back operations are allowed.
- `a`/`b` may change freely after edge k.

## Test plan
- Reset: hold `reset`=0 mid-mult at CALC step 10, release -> all outputs 0, no `pronto`, next add operates normally.
- add `a=32'h7FFFFFFF`, `b=1` -> `resultado=32'h80000000`, `overflow=1`, `pronto` 1 cycle after issue. sub 5−5 -> `zero=1`, `overflow=0`.
- beq `a=b=7` -> `desvio=1`. blz `a=-3` -> `desvio=1`. slt `a=-1`, `b=1` -> 1. sll `a=1`, `b=31` -> `32'h80000000`. Code 15 -> `erro=1`.
- mult `a=-6`, `b=7` -> `{hi,resultado}=64'hFFFFFFFF_FFFFFFD6`, `pronto` exactly 33 cycles after issue, `ocupado` high throughout. A second `iniciar` mid-run is ignored.
- div `a=-7`, `b=2` -> `resultado=-3`, `hi=-1`. div `a=9`, `b=0` -> 1-cycle, `resultado=32'hFFFFFFFF`, `hi=9`, `erro=1`.
- Back-to-back: `iniciar` held high through div then add -> add issues in the div's `pronto` cycle and completes 1 cycle later.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo : multi-cycle MIPS-32 ALU, single-cycle ops plus iterative
//                  signed multiply (shift-add) and divide (restoring).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ula_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [3:0]  controle,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resultado,
  output logic [31:0] hi,
  output logic        zero,
  output logic        desvio,
  output logic        overflow,
  output logic        erro,
  output logic        ocupado,
  output logic        pronto
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNEQ = 4'd8;
  localparam logic [3:0] OP_BLZ  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SGT  = 4'd11;
  localparam logic [3:0] OP_MULT = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] resultado_q, resultado_d;
  logic [31:0] hi_q, hi_d;
  logic        zero_q, zero_d;
  logic        desvio_q, desvio_d;
  logic        overflow_q, overflow_d;
  logic        erro_q, erro_d;
  logic        pronto_q, pronto_d;

  logic [31:0] soma, dif, abs_a, abs_b;
  logic        inicia_calc;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_dif;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] prod_fix;

  assign soma        = a + b;
  assign dif         = a - b;
  assign abs_a       = a[31] ? (32'd0 - a) : a;
  assign abs_b       = b[31] ? (32'd0 - b) : b;
  assign inicia_calc = iniciar && ((controle == OP_MULT) ||
                                   ((controle == OP_DIV) && (b != 32'd0)));

  // acc = {partial product, remaining multiplier bits}; shifts right each step
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // acc = {remainder, dividend/quotient}; the shifted remainder always fits in
  // 32 bits because it is below the divisor magnitude (at most 2^31)
  assign div_dif  = {1'b0, acc_q[62:31]} - {1'b0, dvs_q};
  assign div_next = div_dif[32] ? {acc_q[62:0], 1'b0}
                                : {div_dif[31:0], acc_q[30:0], 1'b1};

  assign quo_fix  = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
  assign rem_fix  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  assign prod_fix = neg_q  ? (64'd0 - acc_q)        : acc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= 5'd0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      acc_q       <= 64'd0;
      dvs_q       <= 32'd0;
      resultado_q <= 32'd0;
      hi_q        <= 32'd0;
      zero_q      <= 1'b0;
      desvio_q    <= 1'b0;
      overflow_q  <= 1'b0;
      erro_q      <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      resultado_q <= resultado_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      desvio_q    <= desvio_d;
      overflow_q  <= overflow_d;
      erro_q      <= erro_d;
      pronto_q    <= pronto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (inicia_calc) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIM;
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    resultado_d = resultado_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    desvio_d    = desvio_q;
    overflow_d  = overflow_q;
    erro_d      = erro_q;
    pronto_d    = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (inicia_calc) begin
          cnt_d    = 5'd0;
          is_div_d = (controle == OP_DIV);
          neg_d    = a[31] ^ b[31];
          rneg_d   = a[31];
          acc_d    = {32'd0, abs_a};
          dvs_d    = abs_b;
        end else if (iniciar) begin
          pronto_d   = 1'b1;
          hi_d       = 32'd0;
          desvio_d   = 1'b0;
          overflow_d = 1'b0;
          erro_d     = 1'b0;
          case (controle)
            OP_ADD: begin
              resultado_d = soma;
              overflow_d  = (a[31] == b[31]) && (soma[31] != a[31]);
            end
            OP_SUB: begin
              resultado_d = dif;
              overflow_d  = (a[31] != b[31]) && (dif[31] != a[31]);
            end
            OP_AND:  resultado_d = a & b;
            OP_OR:   resultado_d = a | b;
            OP_NOT:  resultado_d = ~a;
            OP_SLL:  resultado_d = a << b[4:0];
            OP_SRL:  resultado_d = a >> b[4:0];
            OP_BEQ: begin
              resultado_d = dif;
              desvio_d    = (a == b);
            end
            OP_BNEQ: begin
              resultado_d = dif;
              desvio_d    = (a != b);
            end
            OP_BLZ: begin
              resultado_d = a;
              desvio_d    = a[31];
            end
            OP_SLT:  resultado_d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SGT:  resultado_d = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            OP_DIV: begin
              resultado_d = 32'hFFFF_FFFF;
              hi_d        = a;
              erro_d      = 1'b1;
            end
            default: begin
              resultado_d = 32'd0;
              erro_d      = 1'b1;
            end
          endcase
          zero_d = (resultado_d == 32'd0);
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = is_div_q ? div_next : mul_next;
      end
      FIM: begin
        pronto_d   = 1'b1;
        desvio_d   = 1'b0;
        overflow_d = 1'b0;
        erro_d     = 1'b0;
        if (is_div_q) begin
          resultado_d = quo_fix;
          hi_d        = rem_fix;
        end else begin
          resultado_d = prod_fix[31:0];
          hi_d        = prod_fix[63:32];
        end
        zero_d = (resultado_d == 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    ocupado   = (state_q != OCIOSO);
    pronto    = pronto_q;
    resultado = resultado_q;
    hi        = hi_q;
    zero      = zero_q;
    desvio    = desvio_q;
    overflow  = overflow_q;
    erro      = erro_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo : scoreboard bench for ula_multiciclo with an arithmetic
//                     reference model and randomized operations.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic [3:0]  controle = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] resultado, hi;
  logic        zero, desvio, overflow, erro, ocupado, pronto;

  ula_multiciclo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .controle(controle),
    .a(a), .b(b), .resultado(resultado), .hi(hi), .zero(zero),
    .desvio(desvio), .overflow(overflow), .erro(erro),
    .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hv;
    logic        z, d, o, e;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_start = 0;
  int   busy_end = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input int ic);
    exp_t        e;
    longint      sx, sy, s, q, r;
    logic [63:0] p;
    logic [63:0] qv, rv;
    sx = $signed(x);
    sy = $signed(y);
    e.res = 32'd0; e.hv = 32'd0; e.d = 1'b0; e.o = 1'b0; e.e = 1'b0;
    e.cyc = ic + 1;
    case (op)
      4'd0: begin
        s = sx + sy; e.res = x + y;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = sx - sy; e.res = x - y;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = ~x;
      4'd5: e.res = x << y[4:0];
      4'd6: e.res = x >> y[4:0];
      4'd7: begin e.res = x - y; e.d = (x == y); end
      4'd8: begin e.res = x - y; e.d = (x != y); end
      4'd9: begin e.res = x; e.d = (sx < 0); end
      4'd10: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd11: e.res = (sx > sy) ? 32'd1 : 32'd0;
      4'd12: begin
        p = sx * sy;
        e.res = p[31:0]; e.hv = p[63:32]; e.cyc = ic + 34;
      end
      4'd13: begin
        if (y == 32'd0) begin
          e.res = 32'hFFFF_FFFF; e.hv = x; e.e = 1'b1;
        end else begin
          q = sx / sy; r = sx % sy;
          qv = q; rv = r;
          e.res = qv[31:0]; e.hv = rv[31:0]; e.cyc = ic + 34;
        end
      end
      default: e.e = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Monitor: busy flag every cycle, scoreboard pop on every pronto
  always @(negedge clock) begin
    if (reset) begin
      chk("ocupado", {31'd0, ocupado},
          {31'd0, (cyc >= busy_start) && (cyc < busy_end)});
      if (pronto) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_pronto: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("pronto_cycle", cyc, mon_e.cyc);
          chk("resultado", resultado, mon_e.res);
          chk("hi", hi, mon_e.hv);
          chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
          chk("desvio", {31'd0, desvio}, {31'd0, mon_e.d});
          chk("overflow", {31'd0, overflow}, {31'd0, mon_e.o});
          chk("erro", {31'd0, erro}, {31'd0, mon_e.e});
        end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missing_pronto: got 0 expected 1 (cycle %0d)", cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit hold);
    @(negedge clock);
    iniciar = 1'b1; controle = op; a = x; b = y;
    sb.push_back(model(op, x, y, cyc));
    if (op == 4'd12 || (op == 4'd13 && y != 32'd0)) begin
      busy_start = cyc + 1;
      busy_end   = cyc + 34;
    end
    if (!hold) begin
      @(negedge clock);
      iniciar = 1'b0; a = $urandom; b = $urandom; controle = 4'($urandom);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resultado"}, resultado, 32'd0);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_flags"}, {26'd0, zero, desvio, overflow, erro, ocupado, pronto}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [0:5];
    c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF;
    c[3] = 32'h7FFF_FFFF; c[4] = 32'h8000_0000; c[5] = 32'($urandom_range(0, 20));
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 5)] : 32'($urandom);
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] x, y;

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // directed cases
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 0);       wait_idle();
    issue(4'd1, 32'd5, 32'd5, 0);               wait_idle();
    issue(4'd7, 32'd7, 32'd7, 0);               wait_idle();
    issue(4'd9, 32'hFFFF_FFFD, 32'd0, 0);       wait_idle();
    issue(4'd10, 32'hFFFF_FFFF, 32'd1, 0);      wait_idle();
    issue(4'd5, 32'd1, 32'd31, 0);              wait_idle();
    issue(4'd15, 32'd3, 32'd4, 0);              wait_idle();
    issue(4'd13, 32'hFFFF_FFF9, 32'd2, 0);      wait_idle();
    issue(4'd13, 32'd9, 32'd0, 0);              wait_idle();
    issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_idle();
    issue(4'd12, 32'h8000_0000, 32'h8000_0000, 0); wait_idle();

    // mult with a stray iniciar mid-run and operands changing underneath
    issue(4'd12, 32'hFFFF_FFFA, 32'd7, 0);
    repeat (10) @(negedge clock);
    iniciar = 1'b1; controle = 4'd0; a = 32'd1; b = 32'd2;
    @(negedge clock);
    iniciar = 1'b0;
    wait_idle();

    // reset during mult calculation aborts without pronto
    issue(4'd12, 32'd1234, 32'd5678, 0);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    sb.delete();
    busy_end = 0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clock);
    chk_all_zero("abort_hold");
    reset = 1'b1;
    repeat (40) @(negedge clock);
    issue(4'd0, 32'd100, 32'd23, 0); wait_idle();

    // back-to-back: iniciar held through div, add issued in its pronto cycle
    issue(4'd13, 32'd1000, 32'hFFFF_FFFD, 1);
    repeat (33) begin
      @(negedge clock);
      a = $urandom; b = $urandom;
    end
    issue(4'd0, 32'd40, 32'd2, 0);
    wait_idle();

    // randomized
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = pick();
      y  = pick();
      if (op == 4'd13 && $urandom_range(0, 4) == 0) y = 32'd0;
      issue(op, x, y, 0);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
